// File: rtl/dht11_reader.sv
// DHT11 single-wire bus master: host start pulse, sensor handshake, 40-bit
// capture with checksum check; checked bytes are held for the display path.
module dht11_reader #(
  parameter int CLKS_PER_US   = 12,
  parameter int START_LOW_US  = 18000,
  parameter int TIMEOUT_US    = 200,
  parameter int BIT_THRESH_US = 48
) (
  input  logic       hclk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       dht_in,
  output logic       dht_oe,
  output logic       busy,
  output logic       valid,
  output logic [7:0] humidity,
  output logic [7:0] hum_dec,
  output logic [7:0] temperature,
  output logic [7:0] temp_dec,
  output logic       err_timeout,
  output logic       err_checksum
);

  localparam int CNT_MAX = (START_LOW_US > TIMEOUT_US) ? START_LOW_US : TIMEOUT_US;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int PW      = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;

  localparam logic [PW-1:0] PRESC_LAST   = PW'(CLKS_PER_US - 1);
  localparam logic [CW-1:0] START_LAST   = CW'(START_LOW_US - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_US - 1);
  localparam logic [CW-1:0] THRESH       = CW'(BIT_THRESH_US);

  typedef enum logic [2:0] {
    S_IDLE, S_START_LOW, S_WAIT_RESP, S_RESP_LOW,
    S_RESP_HIGH, S_BIT_LOW, S_BIT_HIGH, S_CHECK
  } state_t;

  state_t        state_q, state_d;
  logic          sync1_q, sync2_q, prev_q;
  logic [PW-1:0] presc_q, presc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [5:0]    idx_q, idx_d;
  logic [39:0]   frame_q, frame_d;
  logic          dht_oe_q, dht_oe_d;
  logic          busy_q, busy_d;
  logic          valid_q, valid_d;
  logic          err_to_q, err_to_d;
  logic          err_ck_q, err_ck_d;
  logic [7:0]    hum_q, hum_d, hdec_q, hdec_d, temp_q, temp_d, tdec_q, tdec_d;

  logic          tick, rise, fall, sensor_phase;
  logic [7:0]    sum;

  always_comb begin
    tick = (presc_q == PRESC_LAST);
    rise = sync2_q & ~prev_q;
    fall = ~sync2_q & prev_q;
    sum  = frame_q[39:32] + frame_q[31:24] + frame_q[23:16] + frame_q[15:8];

    state_d      = state_q;
    presc_d      = tick ? '0 : presc_q + 1'b1;
    cnt_d        = tick ? cnt_q + 1'b1 : cnt_q;
    idx_d        = idx_q;
    frame_d      = frame_q;
    dht_oe_d     = dht_oe_q;
    busy_d       = busy_q;
    valid_d      = 1'b0;
    err_to_d     = 1'b0;
    err_ck_d     = 1'b0;
    hum_d        = hum_q;
    hdec_d       = hdec_q;
    temp_d       = temp_q;
    tdec_d       = tdec_q;
    sensor_phase = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_START_LOW;
          dht_oe_d = 1'b1;
          busy_d   = 1'b1;
        end
      end
      S_START_LOW: begin
        if (tick && cnt_q == START_LAST) begin
          state_d  = S_WAIT_RESP;
          dht_oe_d = 1'b0;
        end
      end
      S_WAIT_RESP: begin
        sensor_phase = 1'b1;
        if (fall) state_d = S_RESP_LOW;
      end
      S_RESP_LOW: begin
        sensor_phase = 1'b1;
        if (rise) state_d = S_RESP_HIGH;
      end
      S_RESP_HIGH: begin
        sensor_phase = 1'b1;
        if (fall) begin
          state_d = S_BIT_LOW;
          idx_d   = '0;
        end
      end
      S_BIT_LOW: begin
        sensor_phase = 1'b1;
        if (rise) state_d = S_BIT_HIGH;
      end
      S_BIT_HIGH: begin
        sensor_phase = 1'b1;
        if (fall) begin
          // cnt_q is the high-phase length in whole microseconds
          frame_d = {frame_q[38:0], (cnt_q >= THRESH)};
          if (idx_q == 6'd39) begin
            state_d = S_CHECK;
          end else begin
            idx_d   = idx_q + 6'd1;
            state_d = S_BIT_LOW;
          end
        end
      end
      S_CHECK: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        if (sum == frame_q[7:0]) begin
          valid_d = 1'b1;
          hum_d   = frame_q[39:32];
          hdec_d  = frame_q[31:24];
          temp_d  = frame_q[23:16];
          tdec_d  = frame_q[15:8];
        end else begin
          err_ck_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // An edge arriving on the same cycle as the timeout wins
    if (sensor_phase && state_d == state_q && tick && cnt_q == TIMEOUT_LAST) begin
      state_d  = S_IDLE;
      busy_d   = 1'b0;
      err_to_d = 1'b1;
    end

    if (state_d != state_q || state_q == S_IDLE) begin
      presc_d = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge hclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      prev_q   <= 1'b1;
      presc_q  <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      frame_q  <= '0;
      dht_oe_q <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      err_to_q <= 1'b0;
      err_ck_q <= 1'b0;
      hum_q    <= '0;
      hdec_q   <= '0;
      temp_q   <= '0;
      tdec_q   <= '0;
    end else begin
      state_q  <= state_d;
      sync1_q  <= dht_in;
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
      presc_q  <= presc_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      frame_q  <= frame_d;
      dht_oe_q <= dht_oe_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      err_to_q <= err_to_d;
      err_ck_q <= err_ck_d;
      hum_q    <= hum_d;
      hdec_q   <= hdec_d;
      temp_q   <= temp_d;
      tdec_q   <= tdec_d;
    end
  end

  assign dht_oe       = dht_oe_q;
  assign busy         = busy_q;
  assign valid        = valid_q;
  assign err_timeout  = err_to_q;
  assign err_checksum = err_ck_q;
  assign humidity     = hum_q;
  assign hum_dec      = hdec_q;
  assign temperature  = temp_q;
  assign temp_dec     = tdec_q;

endmodule

// File: tb/tb_dht11_reader.sv
// Bench for dht11_reader: behavioural DHT11 sensor driving the pad, random
// frames checked against a byte-level reference of the checksum rule.
module tb_dht11_reader;

  localparam int CPU = 2;

  logic       hclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       sensor_low = 1'b0;
  logic       dht_in;
  logic       dht_oe, busy, valid, err_timeout, err_checksum;
  logic [7:0] humidity, hum_dec, temperature, temp_dec;

  // Open-drain pad with pull-up: low if either side drives it
  assign dht_in = ~(dht_oe | sensor_low);

  always #5 hclk = ~hclk;

  dht11_reader #(
    .CLKS_PER_US(CPU), .START_LOW_US(20), .TIMEOUT_US(200), .BIT_THRESH_US(48)
  ) dut (
    .hclk(hclk), .rst_n(rst_n), .start(start), .dht_in(dht_in),
    .dht_oe(dht_oe), .busy(busy), .valid(valid),
    .humidity(humidity), .hum_dec(hum_dec),
    .temperature(temperature), .temp_dec(temp_dec),
    .err_timeout(err_timeout), .err_checksum(err_checksum)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pulse monitor
  int   cnt_valid = 0, cnt_to = 0, cnt_ck = 0, n_overlap = 0, n_wide = 0;
  logic pv = 0, pt = 0, pc = 0;
  always @(negedge hclk) begin
    if (rst_n) begin
      cnt_valid += int'(valid);
      cnt_to    += int'(err_timeout);
      cnt_ck    += int'(err_checksum);
      if (int'(valid) + int'(err_timeout) + int'(err_checksum) > 1) n_overlap++;
      if ((valid && pv) || (err_timeout && pt) || (err_checksum && pc)) n_wide++;
    end
    pv = valid; pt = err_timeout; pc = err_checksum;
  end

  // Reference model state: last accepted bytes
  logic [7:0] exp_b [4] = '{8'h00, 8'h00, 8'h00, 8'h00};

  function automatic bit frame_ok(input logic [39:0] f);
    int s;
    s = int'(f[39:32]) + int'(f[31:24]) + int'(f[23:16]) + int'(f[15:8]);
    return (s % 256) == int'(f[7:0]);
  endfunction

  task automatic us(input int n);
    repeat (n * CPU) @(negedge hclk);
  endtask

  task automatic pulse_start();
    @(negedge hclk) start = 1'b1;
    @(negedge hclk) start = 1'b0;
  endtask

  task automatic measure_oe(output int len);
    int w;
    w = 0;
    while (!dht_oe && w < 10) begin w++; @(negedge hclk); end
    len = 0;
    while (dht_oe && len < 1000) begin len++; @(negedge hclk); end
  endtask

  task automatic check_outputs(input string tag);
    check_val({tag, "_hum"},  humidity,    exp_b[0]);
    check_val({tag, "_hdec"}, hum_dec,     exp_b[1]);
    check_val({tag, "_temp"}, temperature, exp_b[2]);
    check_val({tag, "_tdec"}, temp_dec,    exp_b[3]);
  endtask

  task automatic do_read(input string tag, input logic [39:0] f, input int stall_bit, input bit mid_start);
    int v0, t0, c0, len, w;
    bit ev, et, ec;
    v0 = cnt_valid; t0 = cnt_to; c0 = cnt_ck;
    pulse_start();
    measure_oe(len);
    check_val({tag, "_oe_len_ok"}, 32'(len >= 39 && len <= 41), 1);
    check_val({tag, "_busy_run"}, busy, 1);
    us(30);
    sensor_low = 1'b1; us(80);
    sensor_low = 1'b0; us(80);
    for (int i = 0; i < 40; i++) begin
      sensor_low = 1'b1;
      if (mid_start && i == 20) begin
        @(negedge hclk) start = 1'b1;
        @(negedge hclk) start = 1'b0;
        repeat (50 * CPU - 2) @(negedge hclk);
      end else begin
        us(50);
      end
      sensor_low = 1'b0;
      if (i == stall_bit) break;
      us(f[39 - i] ? 70 : 27);
    end
    if (stall_bit < 0) begin
      sensor_low = 1'b1; us(50); sensor_low = 1'b0;
    end
    w = 0;
    while (busy && w < 2000) begin w++; @(negedge hclk); end
    check_val({tag, "_busy_done"}, busy, 0);
    us(10);
    check_val({tag, "_no_requeue"}, busy, 0);

    et = (stall_bit >= 0);
    ev = !et && frame_ok(f);
    ec = !et && !frame_ok(f);
    if (ev) begin
      exp_b[0] = f[39:32]; exp_b[1] = f[31:24]; exp_b[2] = f[23:16]; exp_b[3] = f[15:8];
    end
    check_val({tag, "_valid_cnt"}, 32'(cnt_valid - v0), 32'(ev));
    check_val({tag, "_to_cnt"},    32'(cnt_to - t0),    32'(et));
    check_val({tag, "_ck_cnt"},    32'(cnt_ck - c0),    32'(ec));
    check_outputs(tag);
    $display("read %s frame=%010h stall=%0d oe_len=%0d valid=%0d to=%0d ck=%0d out=%02h %02h %02h %02h",
             tag, f, stall_bit, len, cnt_valid - v0, cnt_to - t0, cnt_ck - c0,
             humidity, hum_dec, temperature, temp_dec);
    us(10);
  endtask

  function automatic logic [39:0] rand_frame(input bit corrupt);
    logic [39:0] f;
    int s;
    f[39:8] = $urandom;
    s = int'(f[39:32]) + int'(f[31:24]) + int'(f[23:16]) + int'(f[15:8]);
    if (corrupt) s = s + 1 + int'($urandom_range(0, 254));
    f[7:0] = 8'(s % 256);
    return f;
  endfunction

  initial begin
    int len, n, t0;
    logic [39:0] f;

    repeat (3) @(negedge hclk);
    check_val("rst_oe", dht_oe, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_valid", valid, 0);
    check_val("rst_err_to", err_timeout, 0);
    check_val("rst_err_ck", err_checksum, 0);
    check_outputs("rst");
    rst_n = 1'b1;
    us(5);

    do_read("bad_ck", 40'h37_00_18_05_55, -1, 0);
    do_read("good",   40'h37_00_18_05_54, -1, 0);
    for (int k = 0; k < 2; k++) begin
      f = rand_frame($urandom_range(0, 3) == 0);
      do_read($sformatf("rand%0d", k), f, -1, 0);
    end

    // Sensor never answers
    t0 = cnt_to;
    pulse_start();
    measure_oe(len);
    check_val("noans_oe_len_ok", 32'(len >= 39 && len <= 41), 1);
    n = 0;
    while (!err_timeout && n < 1000) begin n++; @(negedge hclk); end
    check_val("noans_to_delay_ok", 32'(n >= 397 && n <= 403), 1);
    check_val("noans_busy", busy, 0);
    @(negedge hclk);
    check_val("noans_to_cnt", 32'(cnt_to - t0), 1);
    check_outputs("noans");
    $display("read noans oe_len=%0d timeout_after=%0d", len, n);
    us(10);

    do_read("stall12", rand_frame(0), 12, 0);
    do_read("midstart", rand_frame(0), -1, 1);

    // Reset during START_LOW
    pulse_start();
    repeat (10) @(negedge hclk);
    rst_n = 1'b0;
    #1;
    check_val("arst_oe", dht_oe, 0);
    check_val("arst_busy", busy, 0);
    exp_b = '{8'h00, 8'h00, 8'h00, 8'h00};
    check_outputs("arst");
    $display("reset during START_LOW: oe=%0b busy=%0b", dht_oe, busy);
    @(negedge hclk) rst_n = 1'b1;
    us(5);
    do_read("after_rst", rand_frame(0), -1, 0);

    check_val("pulse_overlap", 32'(n_overlap), 0);
    check_val("pulse_wide", 32'(n_wide), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
